counter_sequencer: RTL and testbench

//   Run controller for the first_counter datapath. Drives the counter's enable and

---
 rtl/counter_sequencer_if.sv | 44 ++++
 rtl/counter_sequencer.sv | 122 ++++++++++++
 tb/tb_counter_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Host/counter-side bundle for counter_sequencer.
// Optional macro SEQ_AUTO_RELOAD_EN adds the repeat_mode request bit.
interface counter_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             abort;
`ifdef SEQ_AUTO_RELOAD_EN
  logic             repeat_mode;
`endif
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_reset;
  logic             cnt_enable;
  logic             busy;
  logic             done;
  logic             error;

`ifdef SEQ_AUTO_RELOAD_EN
  // Host and counter side, seen from outside the sequencer
  modport master (
    output start, target, abort, repeat_mode, cnt_value,
    input  cnt_reset, cnt_enable, busy, done, error
  );

  // Sequencer side
  modport slave (
    input  start, target, abort, repeat_mode, cnt_value,
    output cnt_reset, cnt_enable, busy, done, error
  );
`else
  // Host and counter side, seen from outside the sequencer
  modport master (
    output start, target, abort, cnt_value,
    input  cnt_reset, cnt_enable, busy, done, error
  );

  // Sequencer side
  modport slave (
    input  start, target, abort, cnt_value,
    output cnt_reset, cnt_enable, busy, done, error
  );
`endif
endinterface

// File: rtl/counter_sequencer.sv
// Run controller for a free-running counter: clears it, enables it for a
// programmed number of clocks, pulses done, and cross-checks the counter
// against an internal shadow count (sticky error).
// Optional macro SEQ_AUTO_RELOAD_EN: repeat_mode restarts the run after DONE.
module counter_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             error_q, error_d;
  logic             cnt_reset_q, cnt_enable_q, busy_q, done_q;
  logic             run_last_c;
  logic             reload_c;

`ifdef SEQ_AUTO_RELOAD_EN
  logic             rpt_q, rpt_d;
  assign reload_c = rpt_q;
`else
  assign reload_c = 1'b0;
`endif

  // Last RUN cycle: the counter lands on tgt_q at the coming edge
  assign run_last_c = (tgt_q != '0) && (bus.cnt_value == (tgt_q - WIDTH'(1)));

  // Next-state, latched target, shadow count and sticky error
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    shadow_d = shadow_q;
    error_d  = error_q;
`ifdef SEQ_AUTO_RELOAD_EN
    rpt_d    = rpt_q;
`endif

    if (((state_q == S_RUN) || (state_q == S_DONE)) && (bus.cnt_value != shadow_q)) begin
      error_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; abort alone is ignored here
        if (bus.start) begin
          tgt_d   = bus.target;
          error_d = 1'b0;
`ifdef SEQ_AUTO_RELOAD_EN
          rpt_d   = bus.repeat_mode && (bus.target != '0);
`endif
          state_d = (bus.target == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        // The counter is cleared at this edge even if the run is aborted
        shadow_d = '0;
        state_d  = bus.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // Enable is high for this whole cycle, so the counter steps even on abort
        shadow_d = shadow_q + WIDTH'(1);
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (run_last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = reload_c ? S_CLEAR : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered output decode of the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tgt_q        <= '0;
      shadow_q     <= '0;
      error_q      <= 1'b0;
      cnt_reset_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQ_AUTO_RELOAD_EN
      rpt_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      shadow_q     <= shadow_d;
      error_q      <= error_d;
      cnt_reset_q  <= (state_d == S_CLEAR);
      cnt_enable_q <= (state_d == S_RUN);
      busy_q       <= (state_d == S_CLEAR) || (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
`ifdef SEQ_AUTO_RELOAD_EN
      rpt_q        <= rpt_d;
`endif
    end
  end

  assign bus.cnt_reset  = cnt_reset_q;
  assign bus.cnt_enable = cnt_enable_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed run table, hand sequences for
// abort / async reset / auto-reload, then randomized traffic against a
// cycle-count reference model. Includes a behavioural counter on the feedback.
module tb_counter_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  counter_sequencer_if #(.WIDTH(4)) bus ();

  counter_sequencer #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural counter driven by the sequencer; stuck_en forces a fault window
  logic [3:0] cnt_real = 4'd0;
  logic       stuck_en = 1'b0;
  always @(posedge clock) begin
    if (bus.cnt_reset)       cnt_real <= 4'd0;
    else if (bus.cnt_enable) cnt_real <= cnt_real + 4'd1;
  end
  assign bus.cnt_value = (stuck_en && (cnt_real >= 4'd3) && (cnt_real <= 4'd4)) ? 4'd2 : cnt_real;

  // Reference model: a run is described by the cycles elapsed since start
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_t = 0;
  bit         m_rpt = 1'b0;
  bit         m_err = 1'b0;
  logic [3:0] m_ideal = 4'd0;
  int         m_ph;

  // 0 idle, 1 clear, 2 run, 3 done
  function automatic int phase_f(input bit act, input int k, input int t, input bit rpt);
    int kk;
    if (!act) return 0;
    if (t == 0) return 3;
    kk = rpt ? (k % (t + 2)) : k;
    if (kk == 0) return 1;
    if (kk <= t) return 2;
    return 3;
  endfunction

  always_comb m_ph = phase_f(m_active, m_k, m_t, m_rpt);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_t      <= 0;
      m_rpt    <= 1'b0;
      m_err    <= 1'b0;
      m_ideal  <= 4'd0;
    end else begin
      if (((m_ph == 2) || (m_ph == 3)) && (bus.cnt_value != m_ideal)) m_err <= 1'b1;
      if (m_ph == 1)      m_ideal <= 4'd0;
      else if (m_ph == 2) m_ideal <= m_ideal + 4'd1;
      if (m_ph == 0) begin
        if (bus.start) begin
          m_active <= 1'b1;
          m_k      <= 0;
          m_t      <= int'(bus.target);
          m_err    <= 1'b0;
`ifdef SEQ_AUTO_RELOAD_EN
          m_rpt    <= bus.repeat_mode && (bus.target != 4'd0);
`else
          m_rpt    <= 1'b0;
`endif
        end
      end else if (((m_ph == 1) || (m_ph == 2)) && bus.abort) begin
        m_active <= 1'b0;
      end else if ((m_ph == 3) && !m_rpt) begin
        m_active <= 1'b0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  function automatic int out_vec();
    return int'({bus.cnt_reset, bus.cnt_enable, bus.busy, bus.done, bus.error});
  endfunction

  function automatic int exp_vec();
    return int'({m_ph == 1, m_ph == 2, (m_ph == 1) || (m_ph == 2), m_ph == 3, m_err});
  endfunction

  typedef struct {
    int target;
    bit abort_with_start;
    int abort_cnt;       // -1: no abort
    bit stuck;
    int exp_first_done;  // cycles after the accepting edge, -1: never
    int exp_busy;
    int exp_cnt;
    bit exp_err;
  } row_t;

  row_t rows[7];

  initial begin
    int first_done, busy_n, done_n;
    bit aborted;

    bus.start  = 1'b0;
    bus.target = 4'd0;
    bus.abort  = 1'b0;
`ifdef SEQ_AUTO_RELOAD_EN
    bus.repeat_mode = 1'b0;
`endif

    rows[0] = '{5,  1'b0, -1, 1'b0,  6,  6,  5, 1'b0}; // basic run
    rows[1] = '{0,  1'b0, -1, 1'b0,  0,  0,  5, 1'b0}; // zero target
    rows[2] = '{15, 1'b0, -1, 1'b0, 16, 16, 15, 1'b0}; // max target, no wrap
    rows[3] = '{8,  1'b0,  2, 1'b0, -1,  4,  3, 1'b0}; // abort seen at 2, lands on 3
    rows[4] = '{4,  1'b1, -1, 1'b0,  5,  5,  4, 1'b0}; // start+abort: start wins
    rows[5] = '{6,  1'b0, -1, 1'b1,  7,  7,  6, 1'b1}; // feedback stuck at 2
    rows[6] = '{3,  1'b0, -1, 1'b0,  4,  4,  3, 1'b0}; // next start clears error

    // Reset
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("outputs_in_reset", out_vec(), 0);
    reset = 1'b1;
    @(negedge clock);
    check("outputs_after_reset", out_vec(), 0);

    // Directed table
    for (int r = 0; r < 7; r++) begin
      bus.start  = 1'b1;
      bus.target = 4'(rows[r].target);
      bus.abort  = rows[r].abort_with_start;
      stuck_en   = rows[r].stuck;
      @(negedge clock);
      first_done = -1;
      busy_n     = 0;
      aborted    = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.done && (first_done < 0)) first_done = i;
        if (bus.busy) busy_n++;
        if (bus.cnt_reset && (i != 0)) check("late_clear", i, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if ((rows[r].abort_cnt >= 0) && !aborted && bus.cnt_enable &&
            (int'(bus.cnt_value) == rows[r].abort_cnt)) begin
          bus.abort = 1'b1;
          aborted   = 1'b1;
        end
        @(negedge clock);
      end
      check($sformatf("row%0d_done_at", r), first_done, rows[r].exp_first_done);
      check($sformatf("row%0d_busy_cycles", r), busy_n, rows[r].exp_busy);
      check($sformatf("row%0d_cnt_value", r), int'(bus.cnt_value), rows[r].exp_cnt);
      check($sformatf("row%0d_error", r), int'(bus.error), int'(rows[r].exp_err));
      stuck_en = 1'b0;
    end

    // Async reset mid-run: immediate idle, counter value left alone
    bus.start  = 1'b1;
    bus.target = 4'd10;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'b0;
      @(negedge clock);
    end
    check("pre_reset_cnt", int'(bus.cnt_value), 3);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", out_vec(), 0);
    @(negedge clock);
    @(negedge clock);
    check("async_reset_cnt_held", int'(bus.cnt_value), 3);
    reset = 1'b1;
    @(negedge clock);

`ifdef SEQ_AUTO_RELOAD_EN
    // Auto-reload: done every target+2 cycles until abort
    bus.start       = 1'b1;
    bus.target      = 4'd3;
    bus.repeat_mode = 1'b1;
    @(negedge clock);
    first_done = -1;
    done_n     = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.done) begin
        if (first_done < 0) first_done = i;
        done_n++;
      end
      bus.start       = 1'b0;
      bus.repeat_mode = 1'b0;
      @(negedge clock);
    end
    check("reload_first_done", first_done, 4);
    check("reload_done_count", done_n, 3);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) done_n++;
      if (bus.busy) busy_n++;
      @(negedge clock);
    end
    check("reload_abort_done", done_n, 0);
    check("reload_abort_busy", busy_n, 0);
`else
    done_n = 0;
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      check($sformatf("rand_cycle%0d_outputs", c), out_vec(), exp_vec());
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.target = 4'($urandom_range(0, 15));
      bus.abort  = ($urandom_range(0, 11) == 0);
`ifdef SEQ_AUTO_RELOAD_EN
      bus.repeat_mode = ($urandom_range(0, 3) == 0);
`endif
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
